// File: rtl/nlc_pkg.sv
// Shared types and arithmetic helpers for the multi-channel
// nonlinearity corrector.
package nlc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCALE,
    HORNER,
    OUT
  } state_e;

  typedef enum logic [1:0] {
    SEC1,
    SEC2,
    SEC3,
    SEC4
  } sec_e;

  localparam int SW = 128;

  function automatic int idx_mean(input int order);
    return order + 1;
  endfunction

  function automatic int idx_rstd(input int order);
    return order + 2;
  endfunction

  function automatic int idx_limit(input int order);
    return order + 3;
  endfunction

  // Clamp v to the signed range of a w-bit word.
  function automatic logic signed [SW-1:0] sat(
    input logic signed [SW-1:0] v,
    input int                   w
  );
    logic signed [SW-1:0] hi;
    logic signed [SW-1:0] lo;
    hi        = '0;
    hi[w-1]   = 1'b1;
    hi        = hi - 1;
    lo        = ~hi;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/nlc_horner_mac.sv
// Saturating multiply, optional Q.FRAC rescale and add, shared
// by the center-scale step and every Horner step.
module nlc_horner_mac
  import nlc_pkg::*;
#(
  parameter int COEF_W = 48,
  parameter int FRAC   = 24
) (
  input  logic signed [COEF_W:0]   a_i,
  input  logic signed [COEF_W-1:0] b_i,
  input  logic                     shift_i,
  input  logic signed [COEF_W-1:0] c_i,
  output logic signed [COEF_W-1:0] y_o
);

  localparam int PW = 2 * COEF_W + 1;

  logic signed [PW-1:0] prod;
  logic signed [SW-1:0] p;

  always_comb begin
    prod = PW'(a_i) * PW'(b_i);
    p    = SW'(prod);
    if (shift_i) p = p >>> FRAC;
    p    = sat(p, COEF_W) + SW'(c_i);
    y_o  = COEF_W'(sat(p, COEF_W));
  end

endmodule

// File: rtl/nlc_mch.sv
// Multi-channel sectioned-polynomial corrector: capture slots,
// round-robin arbiter, shared Horner engine and coefficient store.
module nlc_mch
  import nlc_pkg::*;
#(
  parameter int N_CH   = 4,
  parameter int ORDER  = 10,
  parameter int X_W    = 21,
  parameter int COEF_W = 48,
  parameter int FRAC   = 24,
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int IDX_W = $clog2(ORDER + 4),
  localparam int K_W   = (ORDER > 1) ? $clog2(ORDER + 1) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_CH-1:0]       srdyi,
  input  logic [N_CH*X_W-1:0]   x_adc,
  output logic [N_CH-1:0]       in_rdy,
  output logic [N_CH-1:0]       ovf,
  output logic                  srdyo,
  output logic [CH_W-1:0]       srdyo_ch,
  output logic signed [X_W-1:0] x_lin,
  output logic                  busy,
  input  logic                  cfg_we,
  input  logic [CH_W-1:0]       cfg_ch,
  input  logic [1:0]            cfg_sec,
  input  logic [IDX_W-1:0]      cfg_idx,
  input  logic [COEF_W-1:0]     cfg_wdata,
  output logic                  cfg_err
);

  localparam int NC = ORDER + 1;

  typedef logic signed [COEF_W-1:0] coef_t;

  state_e                state_q;
  logic [N_CH-1:0]       pend_q, pend_d;
  logic [N_CH-1:0]       ovf_q, ovf_d;
  logic [N_CH-1:0]       load;
  logic signed [X_W-1:0] samp_q [N_CH];
  logic [CH_W-1:0]       last_q, ch_q, gnt_ch;
  logic                  gnt_v, grant;
  logic [1:0]            sec_q, sec_g;
  logic signed [X_W-1:0] x_q, xg;
  logic [X_W-1:0]        mag;
  logic [K_W-1:0]        k_q;
  coef_t                 acc_q, xs_q;

  coef_t          coef_q [N_CH][4][NC];
  coef_t          mean_q [N_CH][4];
  coef_t          rstd_q [N_CH][4];
  logic [X_W-2:0] lim_q  [N_CH];

  logic                  srdyo_q, cfg_err_q;
  logic [CH_W-1:0]       srdyo_ch_q;
  logic signed [X_W-1:0] x_lin_q;
  logic                  cfg_rej, cfg_wr;

  logic signed [COEF_W:0] mac_a;
  coef_t                  mac_b, mac_c, mac_y;
  logic                   mac_sh;
  logic signed [SW-1:0]   rnd_w;

  always_comb begin
    gnt_v  = 1'b0;
    gnt_ch = '0;
    for (int i = 1; i <= N_CH; i++) begin
      if (!gnt_v && pend_q[(int'(last_q) + i) % N_CH]) begin
        gnt_v  = 1'b1;
        gnt_ch = CH_W'((int'(last_q) + i) % N_CH);
      end
    end
  end

  assign grant = gnt_v && (state_q == IDLE);

  assign xg  = samp_q[gnt_ch];
  assign mag = xg[X_W-1] ? -xg : xg;

  // The most negative code has no positive magnitude; pin it low.
  always_comb begin
    sec_g = SEC1;
    if (xg == {1'b1, {(X_W-1){1'b0}}})
      sec_g = SEC1;
    else if (!xg[X_W-1] && xg != '0)
      sec_g = (mag > {1'b0, lim_q[gnt_ch]}) ? SEC4 : SEC3;
    else
      sec_g = (mag > {1'b0, lim_q[gnt_ch]}) ? SEC1 : SEC2;
  end

  always_comb begin
    pend_d = pend_q;
    ovf_d  = ovf_q;
    load   = '0;
    if (grant) pend_d[gnt_ch] = 1'b0;
    for (int c = 0; c < N_CH; c++) begin
      if (srdyi[c]) begin
        if (pend_d[c]) begin
          ovf_d[c] = 1'b1;
        end else begin
          pend_d[c] = 1'b1;
          load[c]   = 1'b1;
        end
      end
    end
  end

  always_comb begin
    mac_sh = 1'b1;
    mac_a  = (COEF_W+1)'(acc_q);
    mac_b  = xs_q;
    mac_c  = coef_q[ch_q][sec_q][k_q];
    if (state_q == SCALE) begin
      mac_sh = 1'b0;
      mac_a  = (COEF_W+1)'(x_q)
             + (COEF_W+1)'(mean_q[ch_q][sec_q]);
      mac_b  = rstd_q[ch_q][sec_q];
      mac_c  = '0;
    end
  end

  nlc_horner_mac #(
    .COEF_W (COEF_W),
    .FRAC   (FRAC)
  ) u_mac (
    .a_i     (mac_a),
    .b_i     (mac_b),
    .shift_i (mac_sh),
    .c_i     (mac_c),
    .y_o     (mac_y)
  );

  assign rnd_w = SW'(acc_q) + (SW'(1) <<< (FRAC - 1));

  assign cfg_rej = (state_q != IDLE) || grant
                || (int'(cfg_ch) >= N_CH)
                || (int'(cfg_idx) > idx_limit(ORDER));
  assign cfg_wr  = cfg_we && !cfg_rej;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      pend_q     <= '0;
      ovf_q      <= '0;
      last_q     <= CH_W'(N_CH - 1);
      ch_q       <= '0;
      sec_q      <= '0;
      x_q        <= '0;
      k_q        <= '0;
      acc_q      <= '0;
      xs_q       <= '0;
      srdyo_q    <= 1'b0;
      srdyo_ch_q <= '0;
      x_lin_q    <= '0;
      cfg_err_q  <= 1'b0;
      for (int c = 0; c < N_CH; c++) samp_q[c] <= '0;
    end else begin
      pend_q    <= pend_d;
      ovf_q     <= ovf_d;
      srdyo_q   <= 1'b0;
      cfg_err_q <= cfg_we && cfg_rej;
      for (int c = 0; c < N_CH; c++) begin
        if (load[c]) samp_q[c] <= x_adc[c*X_W +: X_W];
      end
      unique case (state_q)
        IDLE: begin
          if (grant) begin
            x_q     <= xg;
            ch_q    <= gnt_ch;
            last_q  <= gnt_ch;
            sec_q   <= sec_g;
            state_q <= SCALE;
          end
        end
        SCALE: begin
          xs_q    <= mac_y;
          acc_q   <= coef_q[ch_q][sec_q][ORDER];
          k_q     <= K_W'(ORDER - 1);
          state_q <= HORNER;
        end
        HORNER: begin
          acc_q <= mac_y;
          if (k_q == '0) state_q <= OUT;
          else k_q <= k_q - 1'b1;
        end
        OUT: begin
          x_lin_q    <= X_W'(sat(rnd_w >>> FRAC, X_W));
          srdyo_q    <= 1'b1;
          srdyo_ch_q <= ch_q;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < N_CH; c++) begin
        lim_q[c] <= '0;
        for (int s = 0; s < 4; s++) begin
          mean_q[c][s] <= '0;
          rstd_q[c][s] <= '0;
          for (int i = 0; i < NC; i++) coef_q[c][s][i] <= '0;
        end
      end
    end else if (cfg_wr) begin
      unique case (1'b1)
        (int'(cfg_idx) <= ORDER):
          coef_q[cfg_ch][cfg_sec][cfg_idx] <= cfg_wdata;
        (int'(cfg_idx) == idx_mean(ORDER)):
          mean_q[cfg_ch][cfg_sec] <= cfg_wdata;
        (int'(cfg_idx) == idx_rstd(ORDER)):
          rstd_q[cfg_ch][cfg_sec] <= cfg_wdata;
        default:
          lim_q[cfg_ch] <= cfg_wdata[X_W-2:0];
      endcase
    end
  end

  assign in_rdy   = ~pend_q;
  assign ovf      = ovf_q;
  assign srdyo    = srdyo_q;
  assign srdyo_ch = srdyo_ch_q;
  assign x_lin    = x_lin_q;
  assign busy     = (state_q != IDLE);
  assign cfg_err  = cfg_err_q;

endmodule

// File: tb/tb_nlc_mch.sv
// Scoreboard bench for nlc_mch: identity, sections, arbitration,
// overflow, config rejection, saturation and mid-run reset.
module tb_nlc_mch;

  localparam int N_CH   = 4;
  localparam int ORDER  = 10;
  localparam int X_W    = 21;
  localparam int COEF_W = 48;
  localparam int FRAC   = 24;
  localparam int CH_W   = 2;
  localparam int IDX_W  = $clog2(ORDER + 4);

  localparam logic [COEF_W-1:0] ONE  = 48'h1 << FRAC;
  localparam logic [COEF_W-1:0] MAXC = {1'b0, {(COEF_W-1){1'b1}}};
  localparam logic [COEF_W-1:0] MINC = {1'b1, {(COEF_W-1){1'b0}}};

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic [N_CH-1:0]       srdyi;
  logic [N_CH*X_W-1:0]   x_adc;
  logic [N_CH-1:0]       in_rdy;
  logic [N_CH-1:0]       ovf;
  logic                  srdyo;
  logic [CH_W-1:0]       srdyo_ch;
  logic signed [X_W-1:0] x_lin;
  logic                  busy;
  logic                  cfg_we;
  logic [CH_W-1:0]       cfg_ch;
  logic [1:0]            cfg_sec;
  logic [IDX_W-1:0]      cfg_idx;
  logic [COEF_W-1:0]     cfg_wdata;
  logic                  cfg_err;

  nlc_mch #(
    .N_CH   (N_CH),
    .ORDER  (ORDER),
    .X_W    (X_W),
    .COEF_W (COEF_W),
    .FRAC   (FRAC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .srdyi     (srdyi),
    .x_adc     (x_adc),
    .in_rdy    (in_rdy),
    .ovf       (ovf),
    .srdyo     (srdyo),
    .srdyo_ch  (srdyo_ch),
    .x_lin     (x_lin),
    .busy      (busy),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_sec   (cfg_sec),
    .cfg_idx   (cfg_idx),
    .cfg_wdata (cfg_wdata),
    .cfg_err   (cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ch;
    int val;
    int lat;
    int stamp;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_err = 0;
  int   n_res = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input longint got,
                     input longint exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && srdyo) begin
      n_res++;
      if (sb.size() == 0) begin
        chk("unexpected_srdyo", srdyo, 0);
      end else begin
        mon_e = sb.pop_front();
        chk("srdyo_ch", srdyo_ch, mon_e.ch);
        chk("x_lin", x_lin, mon_e.val);
        if (mon_e.lat > 0)
          chk("latency", cyc - mon_e.stamp, mon_e.lat);
      end
    end
  end

  task automatic push(input int ch, input int v, input int lat);
    exp_t e;
    e.ch    = ch;
    e.val   = v;
    e.lat   = lat;
    e.stamp = cyc + 1;
    sb.push_back(e);
  endtask

  task automatic drive(input int ch, input int x, input bit p,
                       input int v, input int lat);
    srdyi[ch]            = 1'b1;
    x_adc[ch*X_W +: X_W] = X_W'(x);
    if (p) push(ch, v, lat);
    @(negedge clk);
    srdyi = '0;
  endtask

  task automatic cfg_wr(input int ch, input int sec, input int idx,
                        input logic [COEF_W-1:0] d);
    cfg_we    = 1'b1;
    cfg_ch    = CH_W'(ch);
    cfg_sec   = 2'(sec);
    cfg_idx   = IDX_W'(idx);
    cfg_wdata = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic identity(input int ch);
    for (int s = 0; s < 4; s++) begin
      cfg_wr(ch, s, 0, '0);
      cfg_wr(ch, s, 1, ONE);
      cfg_wr(ch, s, ORDER + 1, '0);
      cfg_wr(ch, s, ORDER + 2, ONE);
    end
  endtask

  task automatic wait_idle();
    int n;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy) break;
    end
    if (n == 200) chk("timeout", sb.size(), 0);
  endtask

  task automatic chk_zero_outs(input string tag);
    chk({tag, "_srdyo"}, srdyo, 0);
    chk({tag, "_x_lin"}, x_lin, 0);
    chk({tag, "_srdyo_ch"}, srdyo_ch, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ovf"}, ovf, 0);
    chk({tag, "_cfg_err"}, cfg_err, 0);
  endtask

  int sec_x [6] = '{600, 500, 0, -500, -501, -(1 << 20)};
  int sec_e [6] = '{4, 3, 2, 2, 1, 1};
  int rr_x  [4] = '{10, 20, 30, 40};
  int k;

  initial begin
    srdyi     = '0;
    x_adc     = '0;
    cfg_we    = 1'b0;
    cfg_ch    = '0;
    cfg_sec   = '0;
    cfg_idx   = '0;
    cfg_wdata = '0;
    repeat (3) @(negedge clk);
    chk_zero_outs("reset");
    reset = 1'b0;
    @(negedge clk);

    identity(0);
    chk("cfg_err_ok", cfg_err, 0);
    drive(0, 1000, 1, 1000, 13);
    wait_idle();
    drive(0, -7, 1, -7, 13);
    wait_idle();

    drive(0, 77, 0, 0, 0);
    repeat (4) @(negedge clk);
    chk("busy_mid", busy, 1);
    reset = 1'b1;
    #1;
    chk_zero_outs("mid_reset");
    @(negedge clk);
    reset = 1'b0;
    k = n_res;
    repeat (20) @(negedge clk);
    chk("no_srdyo_after_reset", n_res, k);

    for (int c = 0; c < N_CH; c++) identity(c);
    srdyi = '1;
    for (int c = 0; c < N_CH; c++) begin
      x_adc[c*X_W +: X_W] = X_W'(rr_x[c]);
      push(c, rr_x[c], 13 * (c + 1));
    end
    @(negedge clk);
    srdyi = '0;
    chk("in_rdy_all_pending", in_rdy, 4'b0000);
    @(negedge clk);
    chk("in_rdy_after_grant", in_rdy, 4'b0001);
    wait_idle();

    drive(0, 50, 1, 50, 0);
    drive(2, 5, 1, 5, 0);
    drive(2, 6, 0, 0, 0);
    chk("ovf", ovf, 4'b0100);
    cfg_wr(0, 3, 1, '0);
    chk("cfg_err_busy", cfg_err, 1);
    @(negedge clk);
    chk("cfg_err_pulse", cfg_err, 0);
    wait_idle();
    cfg_wr(0, 3, ORDER + 4, '0);
    chk("cfg_err_idx", cfg_err, 1);
    drive(0, 123, 1, 123, 13);
    wait_idle();

    cfg_wr(1, 0, ORDER + 3, 48'd500);
    for (int s = 0; s < 4; s++) begin
      cfg_wr(1, s, 0, COEF_W'(s + 1) << FRAC);
      cfg_wr(1, s, 1, '0);
    end
    for (int i = 0; i < 6; i++) begin
      drive(1, sec_x[i], 1, sec_e[i], 13);
      wait_idle();
    end

    cfg_wr(3, 3, 1, '0);
    cfg_wr(3, 3, 0, MAXC);
    drive(3, 1, 1, (1 << 20) - 1, 13);
    wait_idle();
    cfg_wr(3, 3, 0, MINC);
    drive(3, 1, 1, -(1 << 20), 13);
    wait_idle();

    chk("ovf_sticky", ovf, 4'b0100);
    chk("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
